gray_sweep_ctrl: RTL and testbench
==================================

GRAY_SWEEP_CTRL -- requirements
Module: gray_sweep_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, code width in bits of the swept binary value and its Gray output.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  sweep request; sampled only in IDLE.
REQ-005 stop  input  1  abort; sampled in RUN and PAUSE.
REQ-006 hold  input  1  pause request; sampled in RUN and PAUSE.
REQ-007 dir  input  1  0 = count up, 1 = count down; latched when start is accepted.
REQ-008 start_val  input  WIDTH  first binary value; latched when start is accepted.
REQ-009 end_val  input  WIDTH  last binary value; latched when start is accepted.
REQ-010 bin  output  WIDTH  current binary value, registered.
REQ-011 gray  output  WIDTH  registered bin ^ (bin >> 1); always updates in the same cycle as bin.
REQ-012 valid  output  1  high for exactly one cycle per swept value.
REQ-013 busy  output  1  high in RUN and PAUSE.
REQ-014 done  output  1  one-cycle pulse on normal completion.
REQ-015 step_cnt  output  WIDTH+1  number of valid cycles in the current or last sweep.

Function
REQ-016 The FSM SHALL have four states: IDLE, RUN, PAUSE and DONE.
REQ-017 IDLE with start=1: SHALL latch dir and end_val, load bin=start_val, clear step_cnt to 0, and move to RUN; bin SHALL first be presented with valid=1 on the following cycle.
REQ-018 In RUN, valid SHALL be 1, and step_cnt SHALL increment at each RUN edge.
REQ-019 RUN edge, stop=1: SHALL move to IDLE, hold bin/gray, and leave done=0; stop has priority over end detection and hold.
REQ-020 RUN edge, bin==end_val latched: SHALL move to DONE with bin unchanged.
REQ-021 Otherwise at a RUN edge: bin SHALL step to bin+1 (dir=0) or bin-1 (dir=1), modulo 2^WIDTH. The next state SHALL be PAUSE if hold=1, else RUN.
REQ-022 In PAUSE, valid SHALL be 0 and bin/gray/step_cnt SHALL hold.
REQ-023 PAUSE with stop=1 SHALL move to IDLE. PAUSE with hold=0 SHALL move to RUN, presenting the held value once; no value is skipped or repeated.
REQ-024 DONE SHALL last exactly one cycle, with done=1 and valid=0, and then move to IDLE.
REQ-025 start SHALL be ignored outside IDLE, including during DONE.
REQ-026 Wrap-around SHALL be legal. The sweep length SHALL be ((end_val-start_val) mod 2^WIDTH)+1 for up, and ((start_val-end_val) mod 2^WIDTH)+1 for down.
REQ-027 A full-range sweep SHALL yield step_cnt=2^WIDTH without overflow.
REQ-028 start_val==end_val SHALL yield exactly one valid cycle, then DONE.
REQ-029 In IDLE, bin, gray and step_cnt SHALL retain their last values, and valid, done and busy SHALL be 0.

Reset
REQ-030 rst=1 SHALL immediately, without a clock edge, force state=IDLE and bin=0, gray=0, valid=0, busy=0, done=0, step_cnt=0, including mid-sweep or mid-pause.
REQ-031 After rst deasserts, the block SHALL accept start on the first rising edge at which rst=0.

Verification
REQ-032 Up sweep: start_val=0, end_val=15, dir=0 -> 16 valid cycles, gray 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000; done one cycle after the last valid; step_cnt=16.
REQ-033 Down wrap: start_val=1, end_val=14, dir=1 -> bin 1,0,15,14; gray 0001,0000,1000,1001; step_cnt=4; done pulses once.
REQ-034 Single value: start_val=end_val=5 -> one valid cycle with bin=0101, gray=0111; done next cycle; step_cnt=1.
REQ-035 Hold: sweep 0..7 up, hold=1 while bin=3 is presented -> valid=0 with bin=4, gray=0110 frozen during PAUSE; on hold=0, bin=4 is presented once, then 5..7; step_cnt=8.
REQ-036 Stop: sweep 0..15 up, stop=1 while bin=6 -> IDLE next cycle, valid=0, done never 1, bin=6 held; a new start is then accepted normally.
REQ-037 Async reset: assert rst between clock edges during RUN -> all outputs 0 before the next edge; start is ignored while rst=1.

Source files
------------

// File: rtl/gray_sweep_ctrl.sv
// Sweeps a binary counter from start_val to end_val (up or down, wrapping) and emits the Gray code, one valid per value.
// All outputs registered; first value one cycle after start accepted; hold pauses without skipping, stop aborts to IDLE.
module gray_sweep_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             dir,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] end_val,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   step_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] BIN_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   CNT_ONE = {{WIDTH{1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] end_q, end_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH:0]   cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    end_d   = end_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dir_d   = dir;
          end_d   = end_val;
          bin_d   = start_val;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Every RUN cycle presented a value, so it counts even when aborted.
        cnt_d = cnt_q + CNT_ONE;
        if (stop) begin
          state_d = S_IDLE;
        end else if (bin_q == end_q) begin
          state_d = S_DONE;
        end else begin
          bin_d   = dir_q ? (bin_q - BIN_ONE) : (bin_q + BIN_ONE);
          state_d = hold ? S_PAUSE : S_RUN;
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (!hold) begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Outputs follow the next state so they are registered alongside it.
    gray_d  = bin_d ^ (bin_d >> 1);
    valid_d = (state_d == S_RUN);
    busy_d  = (state_d == S_RUN) || (state_d == S_PAUSE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      end_q   <= '0;
      bin_q   <= '0;
      gray_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      end_q   <= end_d;
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bin      = bin_q;
  assign gray     = gray_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_cnt = cnt_q;

endmodule

// File: tb/tb_gray_sweep_ctrl.sv
// Bench for gray_sweep_ctrl: sweep-index reference model checked every cycle, plus literal sequences.
module tb_gray_sweep_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0, stop = 1'b0, hold = 1'b0, dir = 1'b0;
  logic [W-1:0] start_val = '0, end_val = '0;
  logic [W-1:0] bin, gray;
  logic         valid, busy, done;
  logic [W:0]   step_cnt;

  int total = 0;
  int bad   = 0;

  gray_sweep_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold), .dir(dir),
    .start_val(start_val), .end_val(end_val),
    .bin(bin), .gray(gray), .valid(valid), .busy(busy), .done(done), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 presenting, 2 paused, 3 done.
  // Position is tracked as an index into a sweep whose length comes from the modular distance.
  int           m_ph = 0, m_k = 0, m_len = 0, m_cnt = 0;
  logic [W-1:0] m_bin = '0, m_sv = '0, m_off;
  logic         m_dir = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = 0; m_bin = '0; m_cnt = 0;
    end else begin
      case (m_ph)
        0: if (start) begin
          m_sv = start_val; m_dir = dir; m_k = 0; m_cnt = 0; m_bin = start_val;
          m_off = dir ? (start_val - end_val) : (end_val - start_val);
          m_len = int'(m_off) + 1;
          m_ph = 1;
        end
        1: begin
          m_cnt++;
          if (stop) m_ph = 0;
          else if (m_k == m_len - 1) m_ph = 3;
          else begin
            m_k++;
            m_off = m_k[W-1:0];
            m_bin = m_dir ? (m_sv - m_off) : (m_sv + m_off);
            m_ph  = hold ? 2 : 1;
          end
        end
        2: if (stop) m_ph = 0; else if (!hold) m_ph = 1;
        default: m_ph = 0;
      endcase
    end
  end

  logic [W-1:0] obs_bin[$];
  logic [W-1:0] obs_gray[$];
  int done_seen = 0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("bin",      bin,      m_bin);
      chk("gray",     gray,     m_bin ^ (m_bin >> 1));
      chk("valid",    valid,    m_ph == 1);
      chk("busy",     busy,     m_ph == 1 || m_ph == 2);
      chk("done",     done,     m_ph == 3);
      chk("step_cnt", step_cnt, m_cnt);
      if (valid) begin obs_bin.push_back(bin); obs_gray.push_back(gray); end
      if (done) done_seen++;
    end
  end

  task automatic go(input logic [W-1:0] sv, input logic [W-1:0] ev, input logic d);
    @(negedge clk);
    start_val = sv; end_val = ev; dir = d; start = 1'b1;
    obs_bin.delete(); obs_gray.delete(); done_seen = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 200) begin @(negedge clk); n++; end
    chk("idle_timeout", int'(n < 200), 1);
  endtask

  task automatic wait_val(input logic [W-1:0] v);
    int n = 0;
    while (!(valid && bin == v) && n < 100) begin @(negedge clk); n++; end
    chk("wait_val_timeout", int'(n < 100), 1);
  endtask

  logic [W-1:0] g_up[16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                             4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
  logic [W-1:0] b_dn[4] = '{4'd1, 4'd0, 4'd15, 4'd14};
  logic [W-1:0] g_dn[4] = '{4'b0001, 4'b0000, 4'b1000, 4'b1001};

  initial begin
    #2;
    chk("rst_bin", bin, 0);     chk("rst_gray", gray, 0);   chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);   chk("rst_cnt", step_cnt, 0);
    @(negedge clk); rst = 1'b0;

    // full-range up sweep
    go(4'd0, 4'd15, 1'b0);
    wait_idle();
    chk("up_len", obs_gray.size(), 16);
    for (int i = 0; i < 16 && i < obs_gray.size(); i++) begin
      chk("up_gray", obs_gray[i], g_up[i]);
      chk("up_bin", obs_bin[i], i);
    end
    chk("up_cnt", step_cnt, 16);
    chk("up_done", done_seen, 1);

    // downward wrap
    go(4'd1, 4'd14, 1'b1);
    wait_idle();
    chk("dn_len", obs_bin.size(), 4);
    for (int i = 0; i < 4 && i < obs_bin.size(); i++) begin
      chk("dn_bin", obs_bin[i], b_dn[i]);
      chk("dn_gray", obs_gray[i], g_dn[i]);
    end
    chk("dn_cnt", step_cnt, 4);
    chk("dn_done", done_seen, 1);

    // single value
    go(4'd5, 4'd5, 1'b0);
    wait_idle();
    chk("one_len", obs_bin.size(), 1);
    if (obs_bin.size() > 0) begin
      chk("one_bin", obs_bin[0], 4'b0101);
      chk("one_gray", obs_gray[0], 4'b0111);
    end
    chk("one_cnt", step_cnt, 1);
    chk("one_done", done_seen, 1);

    // hold while 3 presented
    go(4'd0, 4'd7, 1'b0);
    wait_val(4'd3);
    hold = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("pause_valid", valid, 0); chk("pause_bin", bin, 4); chk("pause_gray", gray, 4'b0110);
    end
    hold = 1'b0;
    wait_idle();
    chk("hold_len", obs_bin.size(), 8);
    for (int i = 0; i < 8 && i < obs_bin.size(); i++) chk("hold_bin", obs_bin[i], i);
    chk("hold_cnt", step_cnt, 8);

    // stop while 6 presented
    go(4'd0, 4'd15, 1'b0);
    wait_val(4'd6);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_valid", valid, 0); chk("stop_busy", busy, 0); chk("stop_bin", bin, 6);
    chk("stop_cnt", step_cnt, 7);
    repeat (3) @(negedge clk);
    chk("stop_done", done_seen, 0);
    go(4'd2, 4'd4, 1'b0);
    wait_idle();
    chk("restart_len", obs_bin.size(), 3);
    if (obs_bin.size() > 2) chk("restart_last", obs_bin[2], 4);

    // start held through RUN and DONE is not re-accepted there
    @(negedge clk);
    start_val = 4'd3; end_val = 4'd3; dir = 1'b0; start = 1'b1;
    obs_bin.delete(); obs_gray.delete(); done_seen = 0;
    @(negedge clk); start_val = 4'd9;
    @(negedge clk);
    chk("ign_done", done, 1);
    @(negedge clk); start = 1'b0;
    chk("ign_busy", busy, 0);
    chk("ign_vals", obs_bin.size(), 1);
    chk("ign_bin", bin, 3);

    // async reset mid-run
    go(4'd0, 4'd15, 1'b0);
    wait_val(4'd2);
    @(posedge clk); #3;
    rst = 1'b1; start = 1'b1; start_val = 4'd9; end_val = 4'd10;
    #1;
    chk("arst_bin", bin, 0);   chk("arst_gray", gray, 0); chk("arst_valid", valid, 0);
    chk("arst_busy", busy, 0); chk("arst_cnt", step_cnt, 0);
    repeat (2) @(negedge clk);
    chk("arst_ignore", busy, 0);
    rst = 1'b0;
    @(negedge clk); start = 1'b0;
    chk("post_rst_valid", valid, 1);
    chk("post_rst_bin", bin, 9);
    wait_idle();
    chk("post_rst_cnt", step_cnt, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
